// File: rtl/csdiv_if.sv
// Start/done handshake and operand/result bus between the controlling FSM
// (master) and the csdiv sequential divider (slave).
//
// Handshake: the master raises start with x/y valid; the divider accepts it
// only at a rising edge where it is idle. The accepted x/y are captured on that
// edge, so they may change afterwards. start is ignored while busy or done.
// The divider answers with a one-cycle done pulse. q/r/dbz are valid in that
// cycle and are held until the next accepted start.
interface csdiv_if #(
  parameter int W = 5
);
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         done;
  logic         busy;
  logic         dbz;

  modport master (
    output start, x, y,
    input  q, r, done, busy, dbz
  );

  modport slave (
    input  start, x, y,
    output q, r, done, busy, dbz
  );
endinterface

// File: rtl/csdiv.sv
// Sequential W-bit unsigned restoring divider. It produces one quotient bit per
// cycle. The trial subtraction A - Y is done as A + {1,~Y} + 1 on a (W+1)-bit
// carry-select adder. The low SPLIT bits ripple. The high part is precomputed
// for carry-in 0 and 1, and the low carry-out selects between them.
module csdiv #(
  parameter int W     = 5,
  parameter int SPLIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  csdiv_if.slave     dif,
  output logic [1:0] state_o
);

  localparam int AW = W + 1;          // partial remainder width
  localparam int HI = AW - SPLIT;     // width of the high carry-select half
  localparam int CW = $clog2(W + 1);  // step counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] a_q;
  logic [W-1:0]  qr_q;
  logic [W-1:0]  yr_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  q_q;
  logic [W-1:0]  r_q;
  logic          done_q;
  logic          busy_q;
  logic          dbz_q;

  // One restoring step: shift {A,Q} left, then trial-subtract the divisor.
  logic [AW-1:0]  a_sh;
  logic [AW-1:0]  b_op;
  logic [SPLIT:0] low_sum;
  logic [HI:0]    hi_sum0;
  logic [HI:0]    hi_sum1;
  logic [HI:0]    hi_sel;
  logic [AW-1:0]  trial;
  logic           no_borrow;
  logic [AW-1:0]  a_d;
  logic [W-1:0]   qr_d;

  // Carry-select trial subtractor and the restore/keep decision.
  always_comb begin
    a_sh    = {a_q[W-1:0], qr_q[W-1]};
    b_op    = {1'b1, ~yr_q};
    low_sum = {1'b0, a_sh[SPLIT-1:0]} + {1'b0, b_op[SPLIT-1:0]}
              + {{SPLIT{1'b0}}, 1'b1};
    hi_sum0 = {1'b0, a_sh[AW-1:SPLIT]} + {1'b0, b_op[AW-1:SPLIT]};
    hi_sum1 = {1'b0, a_sh[AW-1:SPLIT]} + {1'b0, b_op[AW-1:SPLIT]}
              + {{HI{1'b0}}, 1'b1};
    hi_sel  = low_sum[SPLIT] ? hi_sum1 : hi_sum0;
    trial   = {hi_sel[HI-1:0], low_sum[SPLIT-1:0]};
    // A carry-out means there is no borrow, so A_shifted >= Yr.
    no_borrow = hi_sel[HI];
    a_d     = no_borrow ? trial : a_sh;
    qr_d    = {qr_q[W-2:0], no_borrow};
  end

  // Control FSM with registered outputs. It also updates the datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      qr_q    <= '0;
      yr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (dif.start) begin
            if (dif.y == '0) begin
              // Divide by zero: report at once with the saturated quotient.
              q_q     <= '1;
              r_q     <= dif.x;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              a_q     <= '0;
              qr_q    <= dif.x;
              yr_q    <= dif.y;
              cnt_q   <= CW'(W);
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          a_q   <= a_d;
          qr_q  <= qr_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            q_q     <= qr_d;
            r_q     <= a_d[W-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dif.q    = q_q;
  assign dif.r    = r_q;
  assign dif.done = done_q;
  assign dif.busy = busy_q;
  assign dif.dbz  = dbz_q;
  assign state_o  = state_q;

endmodule
